// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM between the
// instruction-fetch requester and the data (load/store) requester.
// Data wins by default. A saturating wait counter gives fetch one grant once
// it has been denied MAX_WAIT cycles in a row. The owner of the in-flight read
// is recorded in resp_tag, and the next-cycle read data is routed back to it.
//
// Handshake: a request (x_req) is accepted in the same cycle that x_gnt=1.
// Until then the requester holds req/addr/we/wdata stable. A denied request
// leaves no state behind. Reads return x_rvalid=1 exactly one cycle after the
// grant. Writes complete at the granting edge and never produce an rvalid.
module sram_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_INST = 2'd1,
    TAG_DATA = 2'd2
  } tag_e;

  tag_e       resp_tag_q, resp_tag_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       starve;

  // Arbitration, shared-port drive and response routing. Everything is forced
  // to zero while reset is held low.
  always_comb begin
    starve      = 1'b0;
    inst_gnt    = 1'b0;
    data_gnt    = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 4'h0;
    ram_addr    = 32'h0;
    ram_wdata   = 32'h0;
    inst_rvalid = 1'b0;
    inst_rdata  = 32'h0;
    data_rvalid = 1'b0;
    data_rdata  = 32'h0;
    if (reset) begin
      starve = (wait_cnt_q >= 8'(MAX_WAIT));
      if (inst_req && (!data_req || starve)) begin
        inst_gnt = 1'b1;
      end else if (data_req) begin
        data_gnt = 1'b1;
      end

      if (inst_gnt) begin
        ram_en   = 1'b1;
        ram_addr = inst_addr;
      end else if (data_gnt) begin
        ram_en    = 1'b1;
        ram_we    = data_we;
        ram_addr  = data_addr;
        ram_wdata = data_wdata;
      end

      if (resp_tag_q == TAG_INST) begin
        inst_rvalid = 1'b1;
        inst_rdata  = ram_rdata;
      end
      if (resp_tag_q == TAG_DATA) begin
        data_rvalid = 1'b1;
        data_rdata  = ram_rdata;
      end
    end
  end

  // Next-state: the wait counter tracks consecutive denied fetch cycles, and
  // the tag records which requester owns this cycle's read, if any.
  always_comb begin
    wait_cnt_d = 8'h00;
    resp_tag_d = TAG_NONE;
    if (inst_req && !inst_gnt) begin
      wait_cnt_d = (wait_cnt_q == 8'hff) ? wait_cnt_q : wait_cnt_q + 8'd1;
    end
    if (inst_gnt) begin
      resp_tag_d = TAG_INST;
    end else if (data_gnt && (data_we == 4'h0)) begin
      resp_tag_d = TAG_DATA;
    end
  end

  // State register. Reset drops any outstanding read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_tag_q <= TAG_NONE;
      wait_cnt_q <= 8'h00;
    end else begin
      resp_tag_q <= resp_tag_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter (MAX_WAIT = 4).
module tb_sram_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt, inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_we;
  logic [31:0] data_addr, data_wdata;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  sram_port_arbiter #(.MAX_WAIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_gnt    (inst_gnt),
    .inst_rvalid (inst_rvalid),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_rdata  (data_rdata),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  // ---------------- vector record ----------------
  typedef struct {
    logic        rst_n;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic [3:0]  data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] ram_rdata;
    logic        e_inst_gnt;
    logic        e_data_gnt;
    logic        e_inst_rvalid;
    logic [31:0] e_inst_rdata;
    logic        e_data_rvalid;
    logic [31:0] e_data_rdata;
    logic        e_ram_en;
    logic [3:0]  e_ram_we;
    logic [31:0] e_ram_addr;
    logic [31:0] e_ram_wdata;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(
    input logic rst_n, input logic ireq, input logic [31:0] iaddr,
    input logic dreq, input logic [3:0] dwe, input logic [31:0] daddr,
    input logic [31:0] dwdata, input logic [31:0] rrdata,
    input logic eig, input logic edg, input logic eiv, input logic [31:0] eird,
    input logic edv, input logic [31:0] edrd, input logic een,
    input logic [3:0] ewe, input logic [31:0] eaddr, input logic [31:0] ewdata);
    vec_t v;
    v.rst_n = rst_n; v.inst_req = ireq; v.inst_addr = iaddr;
    v.data_req = dreq; v.data_we = dwe; v.data_addr = daddr;
    v.data_wdata = dwdata; v.ram_rdata = rrdata;
    v.e_inst_gnt = eig; v.e_data_gnt = edg; v.e_inst_rvalid = eiv;
    v.e_inst_rdata = eird; v.e_data_rvalid = edv; v.e_data_rdata = edrd;
    v.e_ram_en = een; v.e_ram_we = ewe; v.e_ram_addr = eaddr;
    v.e_ram_wdata = ewdata;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drive just after posedge, compare on negedge, then let the edge commit.
  task automatic apply(input vec_t v, input string tag);
    reset      = v.rst_n;
    inst_req   = v.inst_req;
    inst_addr  = v.inst_addr;
    data_req   = v.data_req;
    data_we    = v.data_we;
    data_addr  = v.data_addr;
    data_wdata = v.data_wdata;
    ram_rdata  = v.ram_rdata;
    @(negedge clk);
    check({tag, ".inst_gnt"},    32'(inst_gnt),    32'(v.e_inst_gnt));
    check({tag, ".data_gnt"},    32'(data_gnt),    32'(v.e_data_gnt));
    check({tag, ".inst_rvalid"}, 32'(inst_rvalid), 32'(v.e_inst_rvalid));
    check({tag, ".inst_rdata"},  inst_rdata,       v.e_inst_rdata);
    check({tag, ".data_rvalid"}, 32'(data_rvalid), 32'(v.e_data_rvalid));
    check({tag, ".data_rdata"},  data_rdata,       v.e_data_rdata);
    check({tag, ".ram_en"},      32'(ram_en),      32'(v.e_ram_en));
    check({tag, ".ram_we"},      32'(ram_we),      32'(v.e_ram_we));
    check({tag, ".ram_addr"},    ram_addr,         v.e_ram_addr);
    check({tag, ".ram_wdata"},   ram_wdata,        v.e_ram_wdata);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] IA = 32'h1c00_0000;

  initial begin
    reset = 1'b0; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0;
    data_we = '0; data_addr = '0; data_wdata = '0; ram_rdata = '0;

    //          rst ireq iaddr        dreq we     daddr     dwdata        ram_rdata     | ig dg iv ird           dv drd           en we     addr          wdata
    // reset held 3 cycles with both requesting: everything quiet
    vecs.push_back(mk(0, 1, IA,           1, 4'h0, 32'h200, 32'h0,         32'h9999_9999, 0, 0, 0, 32'h0,         0, 32'h0,         0, 4'h0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 1, IA,           1, 4'h0, 32'h200, 32'h0,         32'h9999_9999, 0, 0, 0, 32'h0,         0, 32'h0,         0, 4'h0, 32'h0,         32'h0));
    vecs.push_back(mk(0, 1, IA,           1, 4'h0, 32'h200, 32'h0,         32'h9999_9999, 0, 0, 0, 32'h0,         0, 32'h0,         0, 4'h0, 32'h0,         32'h0));
    // release: data wins with counter at 0
    vecs.push_back(mk(1, 1, IA,           1, 4'h0, 32'h200, 32'h0,         32'h9999_9999, 0, 1, 0, 32'h0,         0, 32'h0,         1, 4'h0, 32'h200,       32'h0));
    // load response, idle port
    vecs.push_back(mk(1, 0, IA,           0, 4'h0, 32'h200, 32'h0,         32'h1111_1111, 0, 0, 0, 32'h0,         1, 32'h1111_1111, 0, 4'h0, 32'h0,         32'h0));
    // fetch only
    vecs.push_back(mk(1, 1, IA,           0, 4'h0, 32'h0,   32'h0,         32'haaaa_5555, 1, 0, 0, 32'h0,         0, 32'h0,         1, 4'h0, IA,            32'h0));
    vecs.push_back(mk(1, 0, IA,           0, 4'h0, 32'h0,   32'h0,         32'h0280_0c0c, 0, 0, 1, 32'h0280_0c0c, 0, 32'h0,         0, 4'h0, 32'h0,         32'h0));
    // store beats fetch, no response afterwards
    vecs.push_back(mk(1, 1, IA,           1, 4'hf, 32'h100, 32'hdead_beef, 32'h3333_3333, 0, 1, 0, 32'h0,         0, 32'h0,         1, 4'hf, 32'h100,       32'hdead_beef));
    vecs.push_back(mk(1, 0, IA,           0, 4'h0, 32'h0,   32'h0,         32'h4444_4444, 0, 0, 0, 32'h0,         0, 32'h0,         0, 4'h0, 32'h0,         32'h0));
    // misaligned fetch still granted
    vecs.push_back(mk(1, 1, IA + 32'h2,   0, 4'h0, 32'h0,   32'h0,         32'h0,         1, 0, 0, 32'h0,         0, 32'h0,         1, 4'h0, IA + 32'h2,    32'h0));
    // load granted while fetch response returns (no bubble)
    vecs.push_back(mk(1, 0, IA,           1, 4'h0, 32'h300, 32'h0,         32'h5555_5555, 0, 1, 1, 32'h5555_5555, 0, 32'h0,         1, 4'h0, 32'h300,       32'h0));
    // fetch granted while load response returns
    vecs.push_back(mk(1, 1, IA + 32'h4,   0, 4'h0, 32'h0,   32'h0,         32'h6666_6666, 1, 0, 0, 32'h0,         1, 32'h6666_6666, 1, 4'h0, IA + 32'h4,    32'h0));
    vecs.push_back(mk(1, 0, IA,           0, 4'h0, 32'h0,   32'h0,         32'h7777_7777, 0, 0, 1, 32'h7777_7777, 0, 32'h0,         0, 4'h0, 32'h0,         32'h0));

    @(posedge clk);
    #1;
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Starvation: both request reads continuously. With MAX_WAIT=4 fetch wins
    // on cycles 4 and 9; data wins the rest. exp_q carries read data in order.
    begin
      logic prev_inst, prev_valid, cur_inst;
      logic [31:0] prev_data, rd;
      prev_valid = 1'b0; prev_inst = 1'b0; prev_data = '0;
      for (int k = 0; k < 12; k++) begin
        rd = 32'ha000_0000 + 32'(k);
        cur_inst = ((k % 5) == 4);
        if (prev_valid) exp_q.push_back(rd);
        prev_data = (prev_valid && exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        if (k < 11)
          apply(mk(1, 1, IA + 32'h10, 1, 4'h0, 32'h400, 32'h0, rd,
                   cur_inst, !cur_inst,
                   prev_valid && prev_inst,  (prev_valid && prev_inst)  ? prev_data : 32'h0,
                   prev_valid && !prev_inst, (prev_valid && !prev_inst) ? prev_data : 32'h0,
                   1, 4'h0, cur_inst ? IA + 32'h10 : 32'h400, 32'h0),
                $sformatf("starve%0d", k));
        else
          apply(mk(1, 0, IA, 0, 4'h0, 32'h0, 32'h0, rd, 0, 0,
                   prev_valid && prev_inst,  (prev_valid && prev_inst)  ? prev_data : 32'h0,
                   prev_valid && !prev_inst, (prev_valid && !prev_inst) ? prev_data : 32'h0,
                   0, 4'h0, 32'h0, 32'h0),
                "starve_drain");
        prev_valid = 1'b1;
        prev_inst  = cur_inst;
      end
    end

    // Reset mid-read: fetch granted, reset lands on the next edge; the read
    // is dropped both during reset and in the first cycle after release.
    apply(mk(1, 1, IA + 32'h20, 0, 4'h0, 32'h0, 32'h0, 32'h0,
             1, 0, 0, 32'h0, 0, 32'h0, 1, 4'h0, IA + 32'h20, 32'h0), "rst_mid_gnt");
    apply(mk(0, 0, IA, 1, 4'h0, 32'h500, 32'h0, 32'hbbbb_bbbb,
             0, 0, 0, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0), "rst_mid_hold");
    apply(mk(1, 0, IA, 0, 4'h0, 32'h0, 32'h0, 32'hcccc_cccc,
             0, 0, 0, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0), "rst_mid_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM between the instruction-fetch requester (pre-IF nextpc fetch) and the data-access requester (EX/MEM load/store).
- Arbitrates each cycle, drives the shared port, tracks which requester owns the in-flight read, and routes the 1-cycle-later read data back to it.
- Data wins by default; a wait counter keeps fetch from starving.
- Sits between the pipeline stages and the unified SRAM macro.

Parameters:
- MAX_WAIT, 4, consecutive denied fetch-request cycles after which fetch gets priority for one grant; legal 1..255.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-low reset.
- inst_req  input  1  fetch request this cycle (read only).
- inst_addr  input  32  fetch byte address.
- inst_gnt  output  1  fetch request accepted this cycle (combinational).
- inst_rvalid  output  1  fetch read data valid this cycle.
- inst_rdata  output  32  fetch read data; 0 when inst_rvalid=0.
- data_req  input  1  data request this cycle.
- data_we  input  4  byte write enables; 0 means read.
- data_addr  input  32  data byte address.
- data_wdata  input  32  store data.
- data_gnt  output  1  data request accepted this cycle (combinational).
- data_rvalid  output  1  load data valid this cycle; reads only.
- data_rdata  output  32  load data; 0 when data_rvalid=0.
- ram_en  output  1  shared SRAM enable.
- ram_we  output  4  shared SRAM byte write enables.
- ram_addr  output  32  shared SRAM address.
- ram_wdata  output  32  shared SRAM write data.
- ram_rdata  input  32  SRAM read data, valid the cycle after a read is issued.

Behaviour:
- State:
  - resp_tag: 2-bit register, values NONE/INST/DATA.
  - wait_cnt: 8-bit saturating counter.
- Reset (reset=0 at posedge): resp_tag<=NONE, wait_cnt<=0.
- While reset=0, outputs are forced:
  - inst_gnt=data_gnt=0, ram_en=0, ram_we=0.
  - inst_rvalid=data_rvalid=0, rdata outputs 0.
- Arbitration (combinational, reset=1):
  - starve = (wait_cnt >= MAX_WAIT).
  - Only one requester active → it is granted.
  - Both active and starve=0 → data granted.
  - Both active and starve=1 → inst granted.
  - Neither active → no grant, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Port drive:
  - On a grant, ram_en=1 and ram_addr is the granted requester's address.
  - Data grant: ram_we=data_we, ram_wdata=data_wdata.
  - Inst grant: ram_we=0, ram_wdata=0.
- wait_cnt update:
  - inst_req=1 and inst_gnt=0 → increment, saturating at 255.
  - inst_gnt=1 → clear to 0.
  - inst_req=0 → clear to 0.
- resp_tag update (every cycle, reset=1):
  - INST if inst_gnt.
  - DATA if data_gnt and data_we==0.
  - NONE otherwise, including granted writes.
- Response, exactly one cycle after grant:
  - inst_rvalid = (resp_tag==INST); data_rvalid = (resp_tag==DATA).
  - Matching rdata = ram_rdata; the other rdata is 0.
- Latency:
  - Grant is same-cycle.
  - Read data arrives next cycle.
  - Writes complete at the granting edge and produce no response.
- Back-to-back: a new grant may issue in the same cycle a response is returned; no bubbles are required.
- Requester rules:
  - Hold req/addr/we/wdata stable until granted.
  - A denied request carries no state inside the arbiter.
- Reset mid-operation: an outstanding read is dropped. The next cycle after reset release shows rvalid=0.
- Error: inst_req=1 with inst_addr[1:0]!=0 is still granted; alignment checking is upstream.

Test Plan:
- Reset: hold reset=0 for 3 cycles with both reqs=1 → all gnt/rvalid/ram_en=0. Release → first-cycle data_gnt=1, wait_cnt=1.
- Fetch only: inst_req=1, inst_addr=0x1c000000, ram_rdata=0x02800c0c next cycle → inst_gnt=1 same cycle, ram_addr=0x1c000000, ram_we=0; next cycle inst_rvalid=1, inst_rdata=0x02800c0c, data_rvalid=0.
- Store vs fetch: both req, data_we=4'b1111, data_addr=0x100, data_wdata=0xdeadbeef → data_gnt=1, ram_we=4'hf, ram_wdata=0xdeadbeef, inst_gnt=0. Next cycle: no rvalid.
- Starvation, MAX_WAIT=4: both req continuously (data reads) → data granted cycles 0-3, inst granted cycle 4, data cycles 5-8, inst cycle 9. Each response routed to the correct requester with the other rdata=0.
- Load/fetch alternation: data read granted at cycle n, inst granted at n+1 → cycle n+1 data_rvalid=1 with ram_rdata; cycle n+2 inst_rvalid=1.
- Reset mid-read: inst granted at cycle n, reset=0 at edge n+1 → inst_rvalid=0 during reset and in the first cycle after release.
